port_bus_master: RTL

Initiator end of the 8-bit PicoBlaze-style port bus. It accepts read/write commands from hardwired game logic and turns them into port_id/out_port/strobe cycles toward the game I/O responder. It samples in_port for reads and services the responder's level interrupt with a one-cycle interrupt_ack. It stands in for, or sits beside, the soft processor when game sequencing is done in fabric.

---
 rtl/port_bus_master_pkg.sv | 46 ++++
 rtl/port_bus_master.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/port_bus_master_pkg.sv
// ============================================================================
// Module      : port_bus_master_pkg
// Description : Shared state encoding, port address map and counter limits
//               for the port bus master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package port_bus_master_pkg;

  // Bus master sequencing states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_WAIT     = 3'd2,
    ST_STROBE   = 3'd3,
    ST_HOLD     = 3'd4,
    ST_RESP     = 3'd5,
    ST_IRQ_ACK  = 3'd6,
    ST_IRQ_WAIT = 3'd7
  } state_t;

  // Game I/O responder port map
  localparam logic [7:0] PORT_BTNS      = 8'h00;
  localparam logic [7:0] PORT_SW        = 8'h01;
  localparam logic [7:0] PORT_LED       = 8'h02;
  localparam logic [7:0] PORT_DIG3      = 8'h03;
  localparam logic [7:0] PORT_DIG2      = 8'h04;
  localparam logic [7:0] PORT_DIG1      = 8'h05;
  localparam logic [7:0] PORT_DIG0      = 8'h06;
  localparam logic [7:0] PORT_DP        = 8'h07;
  localparam logic [7:0] PORT_GAME_INFO = 8'h09;
  localparam logic [7:0] PORT_RAND      = 8'h0F;

  // Largest wait/hold count the 4-bit counter can hold
  localparam int unsigned CNT_MAX = 15;

  // Saturate a wait/hold parameter into the 4-bit counter range
  function automatic logic [3:0] clamp_cnt(input int unsigned v);
    if (v > CNT_MAX) return 4'(CNT_MAX);
    return 4'(v);
  endfunction

endpackage

`default_nettype wire

// File: rtl/port_bus_master.sv
// ============================================================================
// Module      : port_bus_master
// Description : Initiator of the 8-bit PicoBlaze-style port bus. Turns game
//               logic read/write commands into port_id/out_port/strobe cycles
//               and acknowledges the responder's level interrupt.
//               Optional macro PORT_BUS_MASTER_IRQ_CNT_EN adds irq_count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module port_bus_master
  import port_bus_master_pkg::*;
#(
  parameter int unsigned RD_WAIT = 0,
  parameter int unsigned WR_HOLD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic       cmd_const,
  input  logic [7:0] cmd_port,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  input  logic       irq_en,
  output logic       irq_taken,
  output logic [7:0] port_id,
  output logic [7:0] out_port,
  input  logic [7:0] in_port,
  output logic       write_strobe,
  output logic       k_write_strobe,
  output logic       read_strobe,
  input  logic       interrupt,
  output logic       interrupt_ack
`ifdef PORT_BUS_MASTER_IRQ_CNT_EN
  ,
  output logic [7:0] irq_count
`endif
);

  localparam logic [3:0] c_rd_wait = clamp_cnt(RD_WAIT);
  localparam logic [3:0] c_wr_hold = clamp_cnt(WR_HOLD);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_cnt;
  logic       r_is_write;
  logic       r_is_const;
  logic       w_irq_req;
  logic       w_accept;

  assign w_irq_req = irq_en && interrupt;
  assign cmd_ready = (r_state == ST_IDLE) && !w_irq_req;
  assign busy      = (r_state != ST_IDLE);
  assign w_accept  = (r_state == ST_IDLE) && (w_next_state == ST_SETUP);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode; interrupt wins over a command offered in the same cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_irq_req)      w_next_state = ST_IRQ_ACK;
        else if (cmd_valid) w_next_state = ST_SETUP;
      end
      ST_SETUP: begin
        if (!r_is_write && (c_rd_wait != 4'd0)) w_next_state = ST_WAIT;
        else                                    w_next_state = ST_STROBE;
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) w_next_state = ST_STROBE;
      end
      ST_STROBE: begin
        if (!r_is_write)              w_next_state = ST_RESP;
        else if (c_wr_hold != 4'd0)   w_next_state = ST_HOLD;
        else                          w_next_state = ST_IDLE;
      end
      ST_HOLD: begin
        if (r_cnt == 4'd0) w_next_state = ST_IDLE;
      end
      ST_RESP:     w_next_state = ST_IDLE;
      ST_IRQ_ACK:  w_next_state = ST_IRQ_WAIT;
      // Hold here until the level drops so one interrupt is acked once
      ST_IRQ_WAIT: begin
        if (!interrupt) w_next_state = ST_IDLE;
      end
      default:     w_next_state = ST_IDLE;
    endcase
  end

  // Shared wait/hold counter: loaded on entry, counts down to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else begin
      case (r_state)
        ST_SETUP:        r_cnt <= c_rd_wait - 4'd1;
        ST_STROBE:       r_cnt <= c_wr_hold - 4'd1;
        ST_WAIT, ST_HOLD: if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        default:         r_cnt <= r_cnt;
      endcase
    end
  end

  // Command capture; port_id keeps the last address while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_id    <= 8'h00;
      out_port   <= 8'h00;
      r_is_write <= 1'b0;
      r_is_const <= 1'b0;
    end else if (w_accept) begin
      port_id    <= cmd_port;
      r_is_write <= cmd_write;
      r_is_const <= cmd_const;
      if (cmd_write) out_port <= cmd_data;
    end
  end

  // Registered strobes and pulses, raised for the cycle spent in their state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_strobe   <= 1'b0;
      k_write_strobe <= 1'b0;
      read_strobe    <= 1'b0;
      rsp_valid      <= 1'b0;
      interrupt_ack  <= 1'b0;
      irq_taken      <= 1'b0;
    end else begin
      write_strobe   <= (w_next_state == ST_STROBE) && r_is_write && !r_is_const;
      k_write_strobe <= (w_next_state == ST_STROBE) && r_is_write &&  r_is_const;
      read_strobe    <= (w_next_state == ST_STROBE) && !r_is_write;
      rsp_valid      <= (w_next_state == ST_RESP);
      interrupt_ack  <= (w_next_state == ST_IRQ_ACK);
      irq_taken      <= (w_next_state == ST_IRQ_ACK);
    end
  end

  // Read data captured at the close of the read strobe cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        rsp_data <= 8'h00;
    else if ((r_state == ST_STROBE) && !r_is_write) rsp_data <= in_port;
  end

`ifdef PORT_BUS_MASTER_IRQ_CNT_EN
  // Acknowledged interrupt counter, wraps naturally at 8 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            irq_count <= 8'h00;
    else if (irq_taken) irq_count <= irq_count + 8'h01;
  end
`endif

endmodule

`default_nettype wire
